// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts word fetches, reads a synchronous
// instruction array through a fixed-latency pipeline and returns responses
// in order through a small backpressured FIFO. Credits bound the number of
// outstanding fetches so the FIFO never overflows and the pipeline never stalls.
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic [1:0]  rsp_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [29:0]      DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CREDITS     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  fault;
    } entry_t;

    // Instruction array and response FIFO storage
    logic [31:0] mem [DEPTH_WORDS];
    entry_t      fifo_mem [FIFO_DEPTH];

    // Pipeline stages; stage 0 is captured on the accept edge
    logic   stage_valid [LATENCY];
    entry_t stage_entry [LATENCY];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] in_flight;

    logic             accept;
    logic             pop;
    logic             push;
    logic [1:0]       req_fault;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] prog_idx;
    logic             prog_in_range;
    entry_t           head;

    // Byte-offset bits of the program address carry no meaning
    logic unused_prog_low;
    assign unused_prog_low = &{1'b0, prog_addr[1:0]};

    // Request decode and handshakes
    assign req_fault[0]  = (req_addr[1:0] != 2'b00);
    assign req_fault[1]  = (req_addr[31:2] >= DEPTH_LIMIT);
    assign req_idx       = req_addr[IDX_W+1:2];
    assign prog_idx      = prog_addr[IDX_W+1:2];
    assign prog_in_range = (prog_addr[31:2] < DEPTH_LIMIT);

    assign req_ready = (in_flight < CREDITS) && !flush;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign push      = stage_valid[LATENCY-1] && !flush;

    // Head entry is masked to zero while the FIFO is empty
    assign head      = fifo_mem[rd_ptr];
    assign rsp_data  = rsp_valid ? head.data  : '0;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_fault = rsp_valid ? head.fault : '0;

    // Program-load write port; out-of-range writes are dropped
    // NOTE: large storage arrays have no reset so they map onto RAM macros;
    // only the control state that says whether an entry is valid is reset.
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem[prog_idx] <= prog_data;
        end
    end

    // Fetch pipeline: synchronous array read joins at stage 0, stages always advance
    // NOTE: non-blocking assignments here and in the write port make a same-edge
    // fetch of the word being written see the old contents (read-before-write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_entry[i] <= '0;
            end
        end else begin
            stage_valid[0]       <= accept;
            stage_entry[0].addr  <= req_addr;
            stage_entry[0].fault <= req_fault;
            if (accept && (req_fault == 2'b00)) begin
                stage_entry[0].data <= mem[req_idx];
            end else begin
                stage_entry[0].data <= NOP_WORD;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= flush ? 1'b0 : stage_valid[i-1];
                stage_entry[i] <= stage_entry[i-1];
            end
        end
    end

    // FIFO payload write at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= stage_entry[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Credit counter: requests accepted and not yet popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   in_flight <= in_flight + CNT_ONE;
                2'b01:   in_flight <= in_flight - CNT_ONE;
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule
